// File: rtl/uart_interrupt_arbiter.sv
// UART interrupt arbiter: latches events, serves the top pending source.
// Optional vector output enabled with `define UART_INT_VECTORED_EN.
package uart_pkg;

  localparam logic [7:0] UART_ISR_VECTOR = 8'hFF;

  localparam logic [2:0] INT_TX_DONE     = 3'd0;
  localparam logic [2:0] INT_CONFIG_FAIL = 3'd1;
  localparam logic [2:0] INT_OVERRUN     = 3'd2;
  localparam logic [2:0] INT_FRAME       = 3'd3;
  localparam logic [2:0] INT_PARITY      = 3'd4;
  localparam logic [2:0] INT_RXD_RDY     = 3'd5;
  localparam logic [2:0] INT_RX_FULL     = 3'd6;
  localparam logic [2:0] INT_CONFIG_REQ  = 3'd7;

  typedef enum logic [1:0] {
    NORMAL     = 2'b00,
    FAST_CLEAR = 2'b01
  } int_mode_e;

  typedef enum logic [2:0] {
    IDLE            = 3'd0,
    PRIO1_WAIT_ACKN = 3'd1,
    PRIO1_CLEAR     = 3'd2,
    PRIO2_WAIT_ACKN = 3'd3,
    PRIO2_CLEAR     = 3'd4,
    PRIO3_WAIT_ACKN = 3'd5,
    PRIO3_CLEAR     = 3'd6
  } normal_interrupt_response_fsm_e;

endpackage

module uart_interrupt_arbiter
  import uart_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] event_i,
  input  logic [1:0] int_mode_i,
  input  logic       vectored_i,
  input  logic       int_ackn_i,
  input  logic       rx_read_i,
  input  logic       tx_write_i,
  output logic       irq_o,
  output logic [2:0] int_id_o,
  output logic [7:0] pending_o,
  output logic       intpend_o,
  output logic [7:0] vector_o
);

  normal_interrupt_response_fsm_e state_q, state_d;
  normal_interrupt_response_fsm_e sel_st;

  logic [7:0] pending_q, pending_d;
  logic [7:0] clr_w;
  logic [2:0] int_id_q, int_id_d;
  logic [2:0] sel_id;
  logic       irq_q, irq_d;
  logic       fast_w, rx_src_w, tx_src_w, exit_w;

  always_comb begin
    sel_id = INT_TX_DONE;
    sel_st = PRIO3_WAIT_ACKN;
    if (pending_q[INT_CONFIG_FAIL]) begin
      sel_id = INT_CONFIG_FAIL;
      sel_st = PRIO1_WAIT_ACKN;
    end else if (pending_q[INT_OVERRUN]) begin
      sel_id = INT_OVERRUN;
      sel_st = PRIO1_WAIT_ACKN;
    end else if (pending_q[INT_FRAME]) begin
      sel_id = INT_FRAME;
      sel_st = PRIO1_WAIT_ACKN;
    end else if (pending_q[INT_PARITY]) begin
      sel_id = INT_PARITY;
      sel_st = PRIO1_WAIT_ACKN;
    end else if (pending_q[INT_CONFIG_REQ]) begin
      sel_id = INT_CONFIG_REQ;
      sel_st = PRIO2_WAIT_ACKN;
    end else if (pending_q[INT_RX_FULL]) begin
      sel_id = INT_RX_FULL;
      sel_st = PRIO2_WAIT_ACKN;
    end else if (pending_q[INT_RXD_RDY]) begin
      sel_id = INT_RXD_RDY;
      sel_st = PRIO2_WAIT_ACKN;
    end
  end

  // P1 ids never match the fast-clear sources, so they need int_ackn_i
  assign fast_w   = (int_mode_i == FAST_CLEAR);
  assign rx_src_w = (int_id_q == INT_RXD_RDY) ||
                    (int_id_q == INT_RX_FULL);
  assign tx_src_w = (int_id_q == INT_TX_DONE);
  assign exit_w   = int_ackn_i |
                    (fast_w & ((rx_src_w & rx_read_i) |
                               (tx_src_w & tx_write_i)));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      int_id_q  <= 3'b000;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      int_id_q  <= int_id_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    int_id_d = int_id_q;
    clr_w    = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          int_id_d = sel_id;
          state_d  = sel_st;
        end
      end
      PRIO1_WAIT_ACKN: begin
        if (exit_w) begin
          clr_w   = 8'd1 << int_id_q;
          state_d = PRIO1_CLEAR;
        end
      end
      PRIO2_WAIT_ACKN: begin
        if (exit_w) begin
          clr_w   = 8'd1 << int_id_q;
          state_d = PRIO2_CLEAR;
        end
      end
      PRIO3_WAIT_ACKN: begin
        if (exit_w) begin
          clr_w   = 8'd1 << int_id_q;
          state_d = PRIO3_CLEAR;
        end
      end
      PRIO1_CLEAR,
      PRIO2_CLEAR,
      PRIO3_CLEAR: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // a fresh event beats a same-cycle clear
  assign pending_d = (pending_q & ~clr_w) | event_i;

  always_comb begin
    irq_d = 1'b0;
    unique case (state_d)
      PRIO1_WAIT_ACKN,
      PRIO2_WAIT_ACKN,
      PRIO3_WAIT_ACKN: irq_d = 1'b1;
      default:         irq_d = 1'b0;
    endcase
  end

  assign irq_o     = irq_q;
  assign int_id_o  = int_id_q;
  assign pending_o = pending_q;
  assign intpend_o = |pending_q;

`ifdef UART_INT_VECTORED_EN
  logic [7:0] vector_q, vector_d;

  assign vector_d = (irq_d & vectored_i) ? UART_ISR_VECTOR : 8'h00;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) vector_q <= 8'h00;
    else          vector_q <= vector_d;
  end

  assign vector_o = vector_q;
`else
  logic unused_vectored;
  assign unused_vectored = vectored_i;
  assign vector_o        = 8'h00;
`endif

endmodule

// File: tb/tb_uart_interrupt_arbiter.sv
// Directed bench for uart_interrupt_arbiter.
// Covers priority, handshake timing, fast clear, set-wins and reset.
module tb_uart_interrupt_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] event_v = 8'h00;
  logic [1:0] mode = 2'b00;
  logic       vect = 1'b1;
  logic       ackn = 1'b0;
  logic       rx_rd = 1'b0;
  logic       tx_wr = 1'b0;
  logic       irq;
  logic [2:0] id;
  logic [7:0] pend;
  logic       ipend;
  logic [7:0] vec;

  int n_chk = 0;
  int n_fail = 0;

`ifdef UART_INT_VECTORED_EN
  localparam logic [7:0] VEC_ON = 8'hFF;
`else
  localparam logic [7:0] VEC_ON = 8'h00;
`endif

  uart_interrupt_arbiter dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .event_i    (event_v),
    .int_mode_i (mode),
    .vectored_i (vect),
    .int_ackn_i (ackn),
    .rx_read_i  (rx_rd),
    .tx_write_i (tx_wr),
    .irq_o      (irq),
    .int_id_o   (id),
    .pending_o  (pend),
    .intpend_o  (ipend),
    .vector_o   (vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ev(input logic [7:0] e);
    event_v = e;
    step(1);
    event_v = 8'h00;
  endtask

  task automatic pulse_ack();
    ackn = 1'b1;
    step(1);
    ackn = 1'b0;
  endtask

  task automatic chk_serving(input string tag, input logic [2:0] eid);
    chk({tag, "_irq"}, irq, 1'b1);
    chk({tag, "_id"}, id, eid);
  endtask

  initial begin
    step(2);
    chk("rst_irq", irq, 1'b0);
    chk("rst_id", id, 3'b000);
    chk("rst_pend", pend, 8'h00);
    chk("rst_ipend", ipend, 1'b0);
    chk("rst_vec", vec, 8'h00);
    rst_n = 1'b1;
    step(2);

    // single event, NORMAL
    pulse_ev(8'h01);
    chk("s_c1_pend", pend, 8'h01);
    chk("s_c1_ipend", ipend, 1'b1);
    chk("s_c1_irq", irq, 1'b0);
    step(1);
    chk_serving("s_c2", 3'd0);
    chk("s_c2_vec", vec, VEC_ON);
    step(3);
    chk("s_c5_irq", irq, 1'b1);
    pulse_ack();
    chk("s_c6_irq", irq, 1'b0);
    chk("s_c6_pend", pend, 8'h00);
    chk("s_c6_ipend", ipend, 1'b0);
    chk("s_c6_vec", vec, 8'h00);
    step(1);
    pulse_ack();
    chk("s_idle_ack_irq", irq, 1'b0);
    step(1);
    chk("s_idle_irq", irq, 1'b0);

    // priority: PARITY, RXD_RDY, TX_DONE
    pulse_ev(8'h31);
    chk("p_pend", pend, 8'h31);
    step(1);
    chk_serving("p_a", 3'd4);
    pulse_ack();
    chk("p_a_clr_irq", irq, 1'b0);
    chk("p_a_pend", pend, 8'h21);
    step(1);
    chk("p_a_idle_irq", irq, 1'b0);
    step(1);
    chk_serving("p_b", 3'd5);
    pulse_ack();
    chk("p_b_pend", pend, 8'h01);
    chk("p_b_clr_irq", irq, 1'b0);
    step(1);
    chk("p_b_idle_irq", irq, 1'b0);
    step(1);
    chk_serving("p_c", 3'd0);
    pulse_ack();
    chk("p_c_pend", pend, 8'h00);
    step(2);

    // no preemption
    pulse_ev(8'h01);
    step(1);
    chk_serving("np_a", 3'd0);
    pulse_ev(8'h04);
    step(2);
    chk_serving("np_hold", 3'd0);
    chk("np_pend", pend, 8'h05);
    pulse_ack();
    chk("np_n1_irq", irq, 1'b0);
    chk("np_n1_pend", pend, 8'h04);
    step(1);
    chk("np_n2_irq", irq, 1'b0);
    step(1);
    chk_serving("np_n3", 3'd2);
    pulse_ack();
    step(2);

    // FAST_CLEAR on RXD_RDY
    mode = 2'b01;
    pulse_ev(8'h20);
    step(1);
    chk_serving("fc_rx", 3'd5);
    rx_rd = 1'b1;
    step(1);
    rx_rd = 1'b0;
    chk("fc_rx_irq", irq, 1'b0);
    chk("fc_rx_pend", pend, 8'h00);
    step(2);

    // FAST_CLEAR on TX_DONE via tx_write
    pulse_ev(8'h01);
    step(1);
    chk_serving("fc_tx", 3'd0);
    tx_wr = 1'b1;
    step(1);
    tx_wr = 1'b0;
    chk("fc_tx_pend", pend, 8'h00);
    step(2);

    // FRAME ignores rx_read / tx_write even in FAST_CLEAR
    pulse_ev(8'h08);
    step(1);
    chk_serving("fc_fr", 3'd3);
    rx_rd = 1'b1;
    tx_wr = 1'b1;
    step(1);
    rx_rd = 1'b0;
    tx_wr = 1'b0;
    chk_serving("fc_fr_hold", 3'd3);
    chk("fc_fr_pend", pend, 8'h08);
    pulse_ack();
    step(2);

    // NORMAL and reserved mode ignore rx_read
    for (int m = 0; m < 2; m++) begin
      mode = (m == 0) ? 2'b00 : 2'b10;
      pulse_ev(8'h20);
      step(1);
      rx_rd = 1'b1;
      step(1);
      rx_rd = 1'b0;
      chk_serving($sformatf("nm%0d", m), 3'd5);
      chk($sformatf("nm%0d_pend", m), pend, 8'h20);
      pulse_ack();
      step(2);
    end
    mode = 2'b00;

    // set wins over clear on RX_FULL
    pulse_ev(8'h40);
    step(1);
    chk_serving("sw", 3'd6);
    event_v = 8'h40;
    ackn = 1'b1;
    step(1);
    event_v = 8'h00;
    ackn = 1'b0;
    chk("sw_irq", irq, 1'b0);
    chk("sw_pend", pend, 8'h40);
    step(2);
    chk_serving("sw_again", 3'd6);
    pulse_ack();
    step(2);

    // async reset mid-handshake
    pulse_ev(8'h02);
    step(1);
    chk_serving("ar", 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_irq", irq, 1'b0);
    chk("ar_id", id, 3'b000);
    chk("ar_pend", pend, 8'h00);
    chk("ar_ipend", ipend, 1'b0);
    chk("ar_vec", vec, 8'h00);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("ar_idle_irq", irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_interrupt_arbiter.md
# uart_interrupt_arbiter

Collects the UART interrupt events (transmit done, configuration fail/request, overrun, frame, parity, RX data ready, RX full) and latches each one as pending. It issues a single `irq_o` to the host, always serving the highest-priority pending source. It sequences the request/acknowledge/clear handshake with the `normal_interrupt_response_fsm_e` state machine and supplies `INTID` to the ISR register and `INTPEND` to the CTR register. It sits between the TX/RX/control units and the register file.

## Interface
- No parameters. The vector value is `UART_ISR_VECTOR` from `uart_pkg`.
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `event_i` in 8: one-cycle event pulses, bit index = `INT_*` ID (bit 0 `INT_TX_DONE` … bit 7 `INT_CONFIG_REQ`).
- `int_mode_i` in 2: `NORMAL` or `FAST_CLEAR`. Any other value is treated as `NORMAL`.
- `vectored_i` in 1: CTR.VECTORED.
- `int_ackn_i` in 1: host acknowledge pulse (ISR read).
- `rx_read_i` in 1: RXR read pulse.
- `tx_write_i` in 1: TXR write pulse.
- `irq_o` out 1: interrupt request, active high.
- `int_id_o` out 3: ID of the source being served.
- `pending_o` out 8: pending bits, same indexing as `event_i`.
- `intpend_o` out 1: OR of `pending_o`.
- `vector_o` out 8: ISR vector on the bus.

## Operation
- **Priority classes:**
  - P1: `CONFIG_FAIL` > `OVERRUN` > `FRAME` > `PARITY`
  - P2: `CONFIG_REQ` > `RX_FULL` > `RXD_RDY`
  - P3: `TX_DONE`
  - Fixed order inside each class.
- **Pending latch:** `event_i[k]` sets `pending[k]` on the next edge. Only the arbiter's clear operation resets the bit.
- **IDLE state:** if any pending bit is set, select the highest source, register its ID into `int_id_o`, and go to `PRIOn_WAIT_ACKN` for that source's class. Otherwise stay in IDLE.
- **PRIOn_WAIT_ACKN state:** `irq_o`=1 and `int_id_o` is held. There is no preemption: a newly pending higher-class source waits.
  - NORMAL mode: exit on `int_ackn_i`.
  - FAST_CLEAR mode: exit on `int_ackn_i`; additionally on `rx_read_i` when serving `RXD_RDY` or `RX_FULL`, and on `tx_write_i` when serving `TX_DONE`.
  - P1 sources always require `int_ackn_i`.
  - On exit, clear `pending[int_id_o]` and go to `PRIOn_CLEAR`.
- **PRIOn_CLEAR state:** `irq_o`=0 for exactly one cycle, then go to IDLE.
- **Simultaneous events:**
  - Event and clear of the same bit in the same cycle: the set wins and the bit stays pending.
  - Multiple events in one cycle: all are latched.
- **Reset:** asynchronous reset at any time, including mid-handshake, forces IDLE. Reset values: all pending bits 0, `irq_o`=0, `int_id_o`=3'b000, `pending_o`=0, `intpend_o`=0, `vector_o`=8'h00.

## Timing
- Event pulse in cycle 0: pending visible in cycle 1; `irq_o`=1 and `int_id_o` valid in cycle 2.
- Acknowledge in cycle n: `irq_o`=0 and pending bit cleared in cycle n+1 (CLEAR state); IDLE in n+2; the next `irq_o` rises at n+3 at the earliest.
- `irq_o` is low for a minimum of 2 cycles between back-to-back requests.
- An acknowledge while in IDLE or CLEAR is ignored.
- All outputs are registered. `intpend_o` is combinational from the registered pending bits.

## Configuration
- **`UART_INT_VECTORED_EN` defined:** `vector_o` = `UART_ISR_VECTOR` (8'hFF) while `irq_o`=1 and `vectored_i`=1; otherwise 8'h00.
- **`UART_INT_VECTORED_EN` undefined:** `vector_o` is tied to 8'h00, `vectored_i` is ignored, and no vector logic is synthesised.

## Test plan
- **Single event, NORMAL mode:** `event_i`=8'b0000_0001 in cycle 0 → `irq_o`=1 and `int_id_o`=000 in cycle 2; `int_ackn_i` in cycle 5 → `irq_o`=0 in cycle 6, `pending_o`=0, `intpend_o`=0.
- **Priority:** `TX_DONE`, `RXD_RDY` and `PARITY` pulsed together → served in the order IDs 100, 101, 000, one acknowledge each; `irq_o` low 2 cycles between each.
- **No preemption:** while serving `TX_DONE`, `OVERRUN` pulses → `int_id_o` stays 000 until acknowledged; then `irq_o` rises again with ID 010 three cycles after the acknowledge.
- **FAST_CLEAR mode:** `RXD_RDY` pending and `rx_read_i` pulsed → cleared without `int_ackn_i`. The same stimulus in NORMAL mode → `irq_o` stays 1. `FRAME` with `rx_read_i` in FAST_CLEAR → not cleared.
- **Set-wins and reset:** `RX_FULL` event coincident with its acknowledge → pending remains 1 and `irq_o` is reasserted. `rst_n_i` low while in WAIT_ACKN → all outputs 0 immediately.
- **Vectored output:** with `UART_INT_VECTORED_EN` defined and `vectored_i`=1 → `vector_o`=8'hFF only while `irq_o`=1. Without the macro → 8'h00 throughout.
